// File: rtl/next_gcd.sv
// next_gcd: subtractive GCD FSM with four-phase Go/Done handshake (optional Zero_err via NEXT_GCD_ZERO_FLAG_EN)
module next_gcd (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] X,
  input  logic [4:0] Y,
  input  logic       Go,
  output logic       Done,
  output logic [4:0] A,
  output logic [4:0] B
`ifdef NEXT_GCD_ZERO_FLAG_EN
  ,
  output logic       Zero_err
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [4:0] a_q, a_d, b_q, b_d;
  // Next-state and datapath: load on accept, one subtraction per CALC edge, hold in DONE until Go drops
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    case (state_q)
      IDLE: if (Go) begin
        a_d = X;
        b_d = Y;
        state_d = CALC;
      end
      CALC: if (a_q == 5'd0 || b_q == 5'd0) begin
        a_d = a_q | b_q;
        b_d = a_q | b_q;
        state_d = DONE;
      end else if (a_q == b_q) state_d = DONE;
      else if (a_q > b_q) a_d = a_q - b_q;
      else b_d = b_q - a_q;
      DONE: state_d = Go ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= 5'd0;
      b_q <= 5'd0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign Done = state_q == DONE;
  assign A = a_q;
  assign B = b_q;
`ifdef NEXT_GCD_ZERO_FLAG_EN
  logic zero_q, zero_d;
  // Zero-operand flag captured on each accept
  always_comb zero_d = (state_q == IDLE && Go) ? (X == 5'd0 || Y == 5'd0) : zero_q;
  // Flag register
  always_ff @(posedge clk) zero_q <= rst ? 1'b0 : zero_d;
  assign Zero_err = zero_q;
`endif
endmodule

// File: tb/tb_next_gcd.sv
// tb_next_gcd: directed self-checking bench for next_gcd with arithmetic GCD/latency model
module tb_next_gcd;
  logic clk = 0, rst = 1, go = 0, done;
  logic [4:0] x = 0, y = 0, a, b;
  int tests = 0, fails = 0;
  int m_gcd = 0;
`ifdef NEXT_GCD_ZERO_FLAG_EN
  logic zero_err;
  next_gcd dut (.clk(clk), .rst(rst), .X(x), .Y(y), .Go(go), .Done(done), .A(a), .B(b), .Zero_err(zero_err));
`else
  next_gcd dut (.clk(clk), .rst(rst), .X(x), .Y(y), .Go(go), .Done(done), .A(a), .B(b));
`endif
  always #5 clk = ~clk;

  function automatic int model_gcd(input int p, input int q);
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic int model_lat(input int p, input int q);
    int s = 0, t;
    if (p == 0 || q == 0) return 2;
    while (q != 0) begin
      s += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    return s + 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every cycle Done is high, both registers must hold the model GCD
  always @(negedge clk) if (!rst && done) begin
    tests++;
    if (a != m_gcd[4:0] || b != m_gcd[4:0]) begin
      fails++;
      $display("FAIL cmp_done: A=%0d B=%0d expected %0d", a, b, m_gcd);
    end
  end

  task automatic run(input int xv, input int yv, input int g, input int lat, input bit scramble);
    int n;
    x = xv[4:0];
    y = yv[4:0];
    go = 1;
    m_gcd = model_gcd(xv, yv);
    for (n = 1; n <= 40; n++) begin
      tick();
      if (done) break;
      if (scramble) begin
        x = 5'($urandom);
        y = 5'($urandom);
      end
    end
    check($sformatf("lat_hand(%0d,%0d)", xv, yv), n, lat);
    check($sformatf("lat_model(%0d,%0d)", xv, yv), n, model_lat(xv, yv));
    check($sformatf("gcd_A(%0d,%0d)", xv, yv), int'(a), g);
    check($sformatf("gcd_B(%0d,%0d)", xv, yv), int'(b), g);
`ifdef NEXT_GCD_ZERO_FLAG_EN
    check($sformatf("zero_err(%0d,%0d)", xv, yv), int'(zero_err), (xv == 0 || yv == 0) ? 1 : 0);
`endif
  endtask

  task automatic drop(input int g);
    go = 0;
    tick();
    check("drop_done", int'(done), 0);
    check("drop_A", int'(a), g);
    check("drop_B", int'(b), g);
  endtask

  initial begin
    tick();
    tick();
    check("rst_done", int'(done), 0);
    check("rst_A", int'(a), 0);
    check("rst_B", int'(b), 0);
    rst = 0;
    x = 5;
    y = 3;
    tick();
    tick();
    check("idle_hold_A", int'(a), 0);
    check("idle_hold_done", int'(done), 0);
    run(18, 10, 2, 7, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_done", int'(done), 1);
      check("hold_A", int'(a), 2);
    end
    drop(2);
    run(31, 1, 1, 32, 0);
    drop(1);
    run(21, 21, 21, 2, 0);
    drop(21);
    run(0, 12, 12, 2, 0);
    drop(12);
    run(12, 0, 12, 2, 0);
    drop(12);
    run(0, 0, 0, 2, 0);
    drop(0);
    run(18, 10, 2, 7, 0);
    drop(2);
    run(24, 9, 3, 6, 0);
    drop(3);
    run(7, 5, 1, 6, 0);
    drop(1);
    x = 30;
    y = 4;
    go = 1;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("midcalc_rst_A", int'(a), 0);
    check("midcalc_rst_B", int'(b), 0);
    check("midcalc_rst_done", int'(done), 0);
    go = 0;
    tick();
    check("post_rst_idle_A", int'(a), 0);
    rst = 1;
    go = 1;
    tick();
    rst = 0;
    go = 0;
    check("rst_over_go_A", int'(a), 0);
    check("rst_over_go_done", int'(done), 0);
    run(30, 4, 2, 10, 0);
    drop(2);
    run(18, 10, 2, 7, 1);
    drop(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/next_gcd.md
NEXT_GCD -- requirements
Module: next_gcd

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 X  input  5  first unsigned operand, sampled only on the Go-accept edge.
REQ-005 Y  input  5  second unsigned operand, sampled only on the Go-accept edge.
REQ-006 Go  input  1  start request, level-sensitive, four-phase handshake with Done.
REQ-007 Done  output  1  high while the result is valid.
REQ-008 A  output  5  working register A; holds GCD(X,Y) while Done=1.
REQ-009 B  output  5  working register B; equals A while Done=1.

Function
REQ-010 The block SHALL be a registered FSM with states IDLE, CALC and DONE; Done SHALL be 1 only in DONE.
REQ-011 IDLE with Go=1 at a rising edge: load A<=X and B<=Y, and go to CALC; with Go=0: stay in IDLE with A and B held.
REQ-012 CALC, one step per edge, in priority order:
- A==0 or B==0: A<=A|B, B<=A|B, go to DONE.
- A==B: go to DONE, registers held.
- A>B: A<=A-B.
- otherwise: B<=B-A.
REQ-013 Subtraction SHALL be 5-bit unsigned, cannot underflow due to the compare, and uses no extra width.
REQ-014 Go SHALL be ignored in CALC; operand changes during CALC SHALL NOT affect the result.
REQ-015 DONE: A, B and Done are held while Go=1; Go=0 at an edge returns to IDLE (Done falls) with A and B retained.
REQ-016 A new operation SHALL start only from IDLE; holding Go=1 permanently yields exactly one computation.
REQ-017 Latency: Done rises after (load edge) + (number of subtractions) + 1 edges.
- Worst case GCD(31,1) = 1 + 30 + 1 = 32 edges.
REQ-018 GCD(0,0) SHALL give A=B=0 with Done asserted; GCD(n,0) and GCD(0,n) SHALL give n.

Reset
REQ-019 rst=1 at a rising edge SHALL force state IDLE, A=0, B=0 and Done=0, from any state, including mid-CALC.
REQ-020 rst SHALL override Go on the same edge; after release, Go is accepted no earlier than the next edge.

Configuration
REQ-021 Macro NEXT_GCD_ZERO_FLAG_EN defined:
- Adds an output port Zero_err, 1 bit.
- Zero_err is registered, set on the Go-accept edge if X==0 or Y==0, and cleared by reset and on the next accept with nonzero operands.
- Zero_err is valid while Done=1.
REQ-022 Macro not defined: the Zero_err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Reset then X=18, Y=10, Go=1 held -> Done rises 7 edges after the accept edge, A=B=2, and Done stays high while Go=1.
REQ-024 X=31, Y=1 -> Done after 32 edges, A=1; X=21, Y=21 -> Done after 2 edges, A=21.
REQ-025 X=0, Y=12 -> A=B=12 after 2 edges; X=0, Y=0 -> A=0, Done=1; with NEXT_GCD_ZERO_FLAG_EN, Zero_err=1 in both cases and 0 for X=18, Y=10.
REQ-026 Four-phase handshake:
- Start X=24, Y=9; while in DONE drop Go -> IDLE with Done=0 and A=3 held.
- Raise Go with X=7, Y=5 -> new result A=1.
REQ-027 Start X=30, Y=4; assert rst for one edge at the 3rd CALC edge -> A=B=0, Done=0, IDLE.
- Restart X=30, Y=4 -> A=2.
REQ-028 Change X and Y every edge during CALC after starting X=18, Y=10 -> result still A=2.
